// File: rtl/rv_wb_pkg.sv
// ---------------------------------------------------------------------------
// rv_wb_pkg
// Shared types and constants for the register-file write-back arbiter
// (rv_wb_arb) and its LSU result FIFO (rv_wb_fifo).
//   wb_state_e  : arbiter FSM state (CLEAR after reset, RUN afterwards)
//   wb_entry_t  : one buffered result {rd, data}
//   rd_live()   : true when a destination index addresses a real register
// ---------------------------------------------------------------------------
package rv_wb_pkg;

    localparam int NUM_REGS      = 32;
    localparam int REG_IDX_W     = 5;
    localparam int XLEN          = 32;
    localparam int WB_FIFO_DEPTH = 2;

    // Count value at which the FIFO refuses further pushes.
    localparam logic [1:0] FIFO_FULL = 2'd2;

    // Clear sequence walks x1..x31; x0 is hard-wired and never written.
    localparam logic [REG_IDX_W-1:0] CLEAR_FIRST = 5'd1;
    localparam logic [REG_IDX_W-1:0] CLEAR_LAST  = 5'd31;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

    // Results targeting x0 are consumed but never reach the register file.
    function automatic logic rd_live(input logic [REG_IDX_W-1:0] rd);
        return (rd != 5'd0);
    endfunction

endpackage

// File: rtl/rv_wb_fifo.sv
// ---------------------------------------------------------------------------
// rv_wb_fifo
// Two-entry {rd, data} FIFO buffering LSU results until the write port is
// free. A pop frees its slot before a push in the same cycle lands, so a
// simultaneous push/pop at count 1 leaves one (new) entry. Pushes at full
// count are ignored and pops at empty are ignored, so the count stays in 0..2.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset (empties FIFO)
//   push, push_rd/_data   enqueue request and payload
//   pop                   dequeue the head
//   head_rd, head_data    current head entry (valid when count != 0)
//   count                 number of stored entries
// ---------------------------------------------------------------------------
module rv_wb_fifo
    import rv_wb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic [REG_IDX_W-1:0] push_rd,
    input  logic [XLEN-1:0]      push_data,
    input  logic                 pop,
    output logic [REG_IDX_W-1:0] head_rd,
    output logic [XLEN-1:0]      head_data,
    output logic [1:0]           count
);

    wb_entry_t  slot0_r;
    wb_entry_t  slot1_r;
    wb_entry_t  slot0_next_s;
    wb_entry_t  slot1_next_s;
    logic [1:0] count_r;
    logic [1:0] count_pop_s;
    logic [1:0] count_next_s;
    logic       do_pop_s;
    logic       do_push_s;

    // Next-state: apply the pop first, then place the push behind what remains.
    always_comb begin
        do_pop_s     = pop && (count_r != 2'd0);
        do_push_s    = push && (count_r < FIFO_FULL);
        slot0_next_s = slot0_r;
        slot1_next_s = slot1_r;
        count_pop_s  = count_r;
        count_next_s = count_r;

        if (do_pop_s) begin
            slot0_next_s = slot1_r;
            slot1_next_s = '0;
            count_pop_s  = count_r - 2'd1;
        end else begin
            count_pop_s  = count_r;
        end

        if (do_push_s) begin
            if (count_pop_s == 2'd0) begin
                slot0_next_s = {push_rd, push_data};
            end else begin
                slot1_next_s = {push_rd, push_data};
            end
            count_next_s = count_pop_s + 2'd1;
        end else begin
            count_next_s = count_pop_s;
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot0_r <= '0;
            slot1_r <= '0;
            count_r <= 2'd0;
        end else begin
            slot0_r <= slot0_next_s;
            slot1_r <= slot1_next_s;
            count_r <= count_next_s;
        end
    end

    assign head_rd   = slot0_r.rd;
    assign head_data = slot0_r.data;
    assign count     = count_r;

endmodule

// File: rtl/rv_wb_arb.sv
// ---------------------------------------------------------------------------
// rv_wb_arb
// Write-back arbiter for a single register-file write port.
//   After reset the FSM sits in CLEAR and writes zero to x1..x31, one per
//   cycle. In RUN it merges a single-cycle ALU result stream (which can only
//   be stalled) with LSU results held in a 2-entry FIFO. ALU wins the port;
//   the FIFO head is written in cycles without an ALU write, and when the
//   FIFO is full an arriving ALU result is stalled so the head can drain.
//   An ALU write to the same register as the FIFO head retires that stale
//   head. Results for x0 are consumed silently. Writes are registered, so a
//   selection in cycle T appears on o_write/o_rd/o_data after edge T+1.
// Ports:
//   i_clk, i_reset_n                 clock, synchronous active-low reset
//   i_alu_valid/_rd/_data, o_alu_stall   ALU result and back-pressure
//   i_lsu_valid/_rd/_data, o_lsu_ready   LSU result valid/ready handshake
//   o_write, o_rd, o_data            register-file write port
//   o_busy                           clear sequence still emerging
//   i_rs1, i_rs2, o_byp*_valid/_data bypass of the write committing at the
//                                    edge the read indices are sampled
// Configuration: define WB_BYPASS_EN to add the bypass ports and registers.
// ---------------------------------------------------------------------------
module rv_wb_arb
    import rv_wb_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_alu_valid,
    input  logic [REG_IDX_W-1:0] i_alu_rd,
    input  logic [XLEN-1:0]      i_alu_data,
    output logic                 o_alu_stall,
    input  logic                 i_lsu_valid,
    output logic                 o_lsu_ready,
    input  logic [REG_IDX_W-1:0] i_lsu_rd,
    input  logic [XLEN-1:0]      i_lsu_data,
    output logic                 o_write,
    output logic [REG_IDX_W-1:0] o_rd,
    output logic [XLEN-1:0]      o_data,
    output logic                 o_busy
`ifdef WB_BYPASS_EN
    ,
    input  logic [REG_IDX_W-1:0] i_rs1,
    input  logic [REG_IDX_W-1:0] i_rs2,
    output logic                 o_byp1_valid,
    output logic [XLEN-1:0]      o_byp1_data,
    output logic                 o_byp2_valid,
    output logic [XLEN-1:0]      o_byp2_data
`endif
);

    wb_state_e            state_r;
    wb_state_e            state_next_s;
    logic [REG_IDX_W-1:0] clr_cnt_r;
    logic [REG_IDX_W-1:0] clr_cnt_next_s;

    logic [1:0]           fifo_count_s;
    logic [REG_IDX_W-1:0] head_rd_s;
    logic [XLEN-1:0]      head_data_s;
    logic                 head_valid_s;
    logic                 push_s;
    logic                 pop_s;

    logic                 alu_stall_s;
    logic                 lsu_ready_s;
    logic                 alu_write_s;
    logic                 head_drop_s;
    logic                 head_write_s;

    logic                 sel_write_s;
    logic [REG_IDX_W-1:0] sel_rd_s;
    logic [XLEN-1:0]      sel_data_s;

    rv_wb_fifo u_fifo (
        .clk       (i_clk),
        .reset_n   (i_reset_n),
        .push      (push_s),
        .push_rd   (i_lsu_rd),
        .push_data (i_lsu_data),
        .pop       (pop_s),
        .head_rd   (head_rd_s),
        .head_data (head_data_s),
        .count     (fifo_count_s)
    );

    assign head_valid_s = (fifo_count_s != 2'd0);

    // FSM state and clear-index registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r   <= CLEAR;
            clr_cnt_r <= CLEAR_FIRST;
        end else begin
            state_r   <= state_next_s;
            clr_cnt_r <= clr_cnt_next_s;
        end
    end

    // Next state, handshakes and write-port selection.
    always_comb begin
        state_next_s   = state_r;
        clr_cnt_next_s = clr_cnt_r;
        alu_stall_s    = 1'b1;
        lsu_ready_s    = 1'b0;
        alu_write_s    = 1'b0;
        head_drop_s    = 1'b0;
        head_write_s   = 1'b0;
        push_s         = 1'b0;
        pop_s          = 1'b0;
        sel_write_s    = 1'b0;
        sel_rd_s       = 5'd0;
        sel_data_s     = 32'd0;

        case (state_r)
            CLEAR: begin
                sel_write_s = 1'b1;
                sel_rd_s    = clr_cnt_r;
                sel_data_s  = 32'd0;
                if (clr_cnt_r == CLEAR_LAST) begin
                    state_next_s = RUN;
                end else begin
                    clr_cnt_next_s = clr_cnt_r + 5'd1;
                end
            end
            RUN: begin
                // Ready depends on the pre-edge count only, so a full FIFO
                // never accepts even when its head drains this cycle.
                lsu_ready_s  = (fifo_count_s < FIFO_FULL);
                alu_stall_s  = i_alu_valid && (fifo_count_s == FIFO_FULL);
                alu_write_s  = i_alu_valid && !alu_stall_s && rd_live(i_alu_rd);
                // The ALU result is newer than a buffered load to the same rd.
                head_drop_s  = alu_write_s && head_valid_s && (head_rd_s == i_alu_rd);
                head_write_s = head_valid_s && !alu_write_s;
                pop_s        = head_drop_s || head_write_s;
                push_s       = i_lsu_valid && lsu_ready_s && rd_live(i_lsu_rd);
                if (alu_write_s) begin
                    sel_write_s = 1'b1;
                    sel_rd_s    = i_alu_rd;
                    sel_data_s  = i_alu_data;
                end else if (head_write_s) begin
                    sel_write_s = 1'b1;
                    sel_rd_s    = head_rd_s;
                    sel_data_s  = head_data_s;
                end else begin
                    sel_write_s = 1'b0;
                end
            end
            default: begin
                state_next_s   = CLEAR;
                clr_cnt_next_s = CLEAR_FIRST;
            end
        endcase
    end

    assign o_alu_stall = alu_stall_s;
    assign o_lsu_ready = lsu_ready_s;

    // Registered write port; busy tracks the clear writes as they emerge.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_write <= 1'b0;
            o_rd    <= 5'd0;
            o_data  <= 32'd0;
            o_busy  <= 1'b1;
        end else begin
            o_write <= sel_write_s;
            o_rd    <= sel_rd_s;
            o_data  <= sel_data_s;
            o_busy  <= (state_r == CLEAR);
        end
    end

`ifdef WB_BYPASS_EN
    logic [REG_IDX_W-1:0] rs1_r;
    logic [REG_IDX_W-1:0] rs2_r;

    // Read indices sampled on the same edge that commits the write.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rs1_r <= 5'd0;
            rs2_r <= 5'd0;
        end else begin
            rs1_r <= i_rs1;
            rs2_r <= i_rs2;
        end
    end

    assign o_byp1_valid = o_write && rd_live(rs1_r) && (o_rd == rs1_r);
    assign o_byp2_valid = o_write && rd_live(rs2_r) && (o_rd == rs2_r);
    assign o_byp1_data  = o_byp1_valid ? o_data : 32'd0;
    assign o_byp2_data  = o_byp2_valid ? o_data : 32'd0;
`endif

endmodule

// File: tb/tb_rv_wb_arb.sv
// ---------------------------------------------------------------------------
// tb_rv_wb_arb
// Randomized bench for rv_wb_arb. A queue-based reference model evaluates
// the arbitration rules at each falling edge and pushes the write it expects
// into a scoreboard queue; a monitor pops and compares whenever the DUT
// strobes o_write. Handshake outputs and o_busy are checked against the
// model too. Define WB_BYPASS_EN to exercise the bypass ports.
// ---------------------------------------------------------------------------
module tb_rv_wb_arb;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } res_t;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_alu_valid;
    logic [4:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        o_alu_stall;
    logic        i_lsu_valid;
    logic        o_lsu_ready;
    logic [4:0]  i_lsu_rd;
    logic [31:0] i_lsu_data;
    logic        o_write;
    logic [4:0]  o_rd;
    logic [31:0] o_data;
    logic        o_busy;
`ifdef WB_BYPASS_EN
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic        o_byp1_valid;
    logic [31:0] o_byp1_data;
    logic        o_byp2_valid;
    logic [31:0] o_byp2_data;
`endif

    rv_wb_arb dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_alu_valid (i_alu_valid),
        .i_alu_rd    (i_alu_rd),
        .i_alu_data  (i_alu_data),
        .o_alu_stall (o_alu_stall),
        .i_lsu_valid (i_lsu_valid),
        .o_lsu_ready (o_lsu_ready),
        .i_lsu_rd    (i_lsu_rd),
        .i_lsu_data  (i_lsu_data),
        .o_write     (o_write),
        .o_rd        (o_rd),
        .o_data      (o_data),
        .o_busy      (o_busy)
`ifdef WB_BYPASS_EN
        ,
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .o_byp1_valid(o_byp1_valid),
        .o_byp1_data (o_byp1_data),
        .o_byp2_valid(o_byp2_valid),
        .o_byp2_data (o_byp2_data)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int   compared   = 0;
    int   mismatched = 0;

    res_t lq[$];          // model of buffered LSU results
    res_t expq[$];        // expected register-file writes, in order
    int   clear_left = 31;
    bit   rst_seen   = 1'b1;
    bit   busy_exp   = 1'b1;
    bit   alu_done   = 1'b0;
    bit   lsu_done   = 1'b0;
    logic [4:0] rs1_s = 5'd0;
    logic [4:0] rs2_s = 5'd0;
    int   p_alu = 0;
    int   p_lsu = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: decide what the DUT must accept and write this cycle.
    always @(negedge i_clk) begin
        bit   stall_e;
        bit   ready_e;
        bit   took_alu;
        res_t r;
        if (!i_reset_n) begin
            lq.delete();
            expq.delete();
            clear_left = 31;
            rst_seen   = 1'b1;
            busy_exp   = 1'b1;
            alu_done   = 1'b0;
            lsu_done   = 1'b0;
        end else begin
            rst_seen = 1'b0;
            busy_exp = (clear_left > 0);
            if (clear_left > 0) begin
                check("clear_stall", 32'(o_alu_stall), 32'd1);
                check("clear_ready", 32'(o_lsu_ready), 32'd0);
                r.rd   = 5'(32 - clear_left);
                r.data = 32'd0;
                expq.push_back(r);
                clear_left--;
                alu_done = 1'b0;
                lsu_done = 1'b0;
            end else begin
                stall_e = i_alu_valid && (lq.size() == 2);
                ready_e = (lq.size() < 2);
                check("alu_stall", 32'(o_alu_stall), 32'(stall_e));
                check("lsu_ready", 32'(o_lsu_ready), 32'(ready_e));
                took_alu = 1'b0;
                if (i_alu_valid && !stall_e && i_alu_rd != 5'd0) begin
                    r.rd   = i_alu_rd;
                    r.data = i_alu_data;
                    expq.push_back(r);
                    took_alu = 1'b1;
                    if (lq.size() > 0 && lq[0].rd == i_alu_rd) begin
                        void'(lq.pop_front());
                    end
                end
                if (!took_alu && lq.size() > 0) begin
                    expq.push_back(lq.pop_front());
                end
                if (i_lsu_valid && ready_e && i_lsu_rd != 5'd0) begin
                    r.rd   = i_lsu_rd;
                    r.data = i_lsu_data;
                    lq.push_back(r);
                end
                alu_done = i_alu_valid && !stall_e;
                lsu_done = i_lsu_valid && ready_e;
            end
        end
`ifdef WB_BYPASS_EN
        rs1_s = i_rs1;
        rs2_s = i_rs2;
`endif
    end

    // Monitor: compare every write the DUT presents against the scoreboard.
    always @(posedge i_clk) begin
        res_t e;
        #1;
        if (rst_seen) begin
            check("rst_write", 32'(o_write), 32'd0);
            check("rst_rd", 32'(o_rd), 32'd0);
            check("rst_data", o_data, 32'd0);
            check("rst_busy", 32'(o_busy), 32'd1);
        end else begin
            check("busy", 32'(o_busy), 32'(busy_exp));
            if (o_write) begin
                if (expq.size() == 0) begin
                    check("unexpected_write_rd", 32'(o_rd), 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    check("write_rd", 32'(o_rd), 32'(e.rd));
                    check("write_data", o_data, e.data);
`ifdef WB_BYPASS_EN
                    check("byp1_valid", 32'(o_byp1_valid), 32'(rs1_s != 5'd0 && rs1_s == e.rd));
                    check("byp1_data", o_byp1_data, (rs1_s != 5'd0 && rs1_s == e.rd) ? e.data : 32'd0);
                    check("byp2_valid", 32'(o_byp2_valid), 32'(rs2_s != 5'd0 && rs2_s == e.rd));
                    check("byp2_data", o_byp2_data, (rs2_s != 5'd0 && rs2_s == e.rd) ? e.data : 32'd0);
`endif
                end
            end else begin
`ifdef WB_BYPASS_EN
                check("byp1_idle", 32'(o_byp1_valid), 32'd0);
                check("byp2_idle", 32'(o_byp2_valid), 32'd0);
`endif
            end
        end
    end

    // Drive one cycle of producer behaviour: hold unconsumed results.
    task automatic drive_cycle();
        @(posedge i_clk);
        #2;
        if (!i_alu_valid || alu_done) begin
            i_alu_valid = ($urandom_range(99, 0) < p_alu);
            i_alu_rd    = 5'($urandom_range(7, 0));
            i_alu_data  = $urandom;
        end
        if (!i_lsu_valid || lsu_done) begin
            i_lsu_valid = ($urandom_range(99, 0) < p_lsu);
            i_lsu_rd    = 5'($urandom_range(7, 0));
            i_lsu_data  = $urandom;
        end
`ifdef WB_BYPASS_EN
        i_rs1 = 5'($urandom_range(7, 0));
        i_rs2 = 5'($urandom_range(7, 0));
`endif
    endtask

    task automatic run_phase(input int cycles, input int pa, input int pl);
        p_alu = pa;
        p_lsu = pl;
        for (int i = 0; i < cycles; i++) begin
            drive_cycle();
        end
    endtask

    initial begin
        i_reset_n   = 1'b0;
        i_alu_valid = 1'b0;
        i_alu_rd    = 5'd0;
        i_alu_data  = 32'd0;
        i_lsu_valid = 1'b0;
        i_lsu_rd    = 5'd0;
        i_lsu_data  = 32'd0;
`ifdef WB_BYPASS_EN
        i_rs1 = 5'd0;
        i_rs2 = 5'd0;
`endif
        run_phase(3, 0, 0);
        i_reset_n = 1'b1;
        // Clear sequence with traffic waiting, then mixed and saturated load.
        run_phase(50, 40, 40);
        run_phase(300, 50, 50);
        run_phase(120, 100, 85);
        // Reset while the FIFO is kept full: buffered entries must vanish.
        run_phase(12, 100, 100);
        i_reset_n = 1'b0;
        run_phase(2, 100, 100);
        i_reset_n = 1'b1;
        run_phase(80, 30, 60);
        run_phase(40, 0, 0);
        compared++;
        if (expq.size() != 0) begin
            mismatched++;
            $display("FAIL drain: actual=%0d pending writes required=0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
